apb_mtimer: RTL and testbench

- APB responder (slave) that answers the core's APB master port.
- Holds the 64-bit machine timer `mtime` and the compare register `mtimecmp`, with a programmable prescaler.
- Drives the core's `mtime` bus and `mtimer_int` inputs.
- Sits on the system APB bus beside other peripherals; the bus decoder asserts `psel` for this block's address window.

---
 rtl/apb_mtimer_pkg.sv | 55 +++++
 rtl/apb_mtimer_prescaler.sv | 37 +++
 rtl/apb_mtimer.sv | 188 ++++++++++++++++++
 tb/tb_apb_mtimer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mtimer_pkg.sv
// ---------------------------------------------------------------------------
// apb_mtimer_pkg
//   Shared definitions for the APB machine-timer block:
//     - register offsets within the block's APB window
//     - mtimer_reg_e, the decoded register select used by the top level
//     - decode_reg(): offset -> register select (REG_NONE = error)
//     - merge_bytes(): byte-strobe merge of write data into a 32-bit register
// ---------------------------------------------------------------------------
package apb_mtimer_pkg;

    localparam logic [31:0] MTIME_LO_OFS    = 32'h0000_0000;
    localparam logic [31:0] MTIME_HI_OFS    = 32'h0000_0004;
    localparam logic [31:0] MTIMECMP_LO_OFS = 32'h0000_0008;
    localparam logic [31:0] MTIMECMP_HI_OFS = 32'h0000_000C;
    localparam logic [31:0] CTRL_OFS        = 32'h0000_0010;
    localparam logic [31:0] PRESCALE_OFS    = 32'h0000_0014;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI,
        REG_CTRL,
        REG_PRESCALE
    } mtimer_reg_e;

    // Misaligned or unmapped offsets decode to REG_NONE, which the top level
    // turns into pslverr.
    function automatic mtimer_reg_e decode_reg(input logic [31:0] ofs);
        mtimer_reg_e sel;
        sel = REG_NONE;
        case (ofs)
            MTIME_LO_OFS:    sel = REG_MTIME_LO;
            MTIME_HI_OFS:    sel = REG_MTIME_HI;
            MTIMECMP_LO_OFS: sel = REG_MTIMECMP_LO;
            MTIMECMP_HI_OFS: sel = REG_MTIMECMP_HI;
            CTRL_OFS:        sel = REG_CTRL;
            PRESCALE_OFS:    sel = REG_PRESCALE;
            default:         sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_mtimer_prescaler.sv
// ---------------------------------------------------------------------------
// apb_mtimer_prescaler
//   Divides the clock down to mtime ticks. The counter runs 0..prescale and
//   the cycle in which it sits at prescale is a tick cycle; it then wraps.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     en          count enable (CTRL.EN); 0 freezes the counter, no ticks
//     prescale    terminal count, mtime ticks every prescale+1 clocks
//     clear       restart counting from 0 (PRESCALE register written)
//     tick        combinational, high in the cycle that advances mtime
// ---------------------------------------------------------------------------
module apb_mtimer_prescaler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] prescale,
    input  logic        clear,
    output logic        tick
);

    logic [15:0] cnt;

    // The tick for the current cycle is decided by the old count; a
    // simultaneous clear only affects where counting resumes.
    assign tick = en & (cnt == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (clear) begin
            cnt <= 16'd0;
        end else if (en) begin
            cnt <= tick ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/apb_mtimer.sv
// ---------------------------------------------------------------------------
// apb_mtimer
//   APB responder holding the 64-bit machine timer (mtime), its compare
//   register (mtimecmp), an enable bit and a clock prescaler. Drives the
//   core's mtime bus and the level-sensitive timer interrupt.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     psel, penable         APB select / access phase
//     paddr                 window-relative byte offset
//     pwrite, pwdata, pwstrb  write control, data and byte strobes
//     pready, prdata, pslverr transfer response (combinational)
//     mtime                 current timer value (register output)
//     mtimer_int            registered (mtime >= mtimecmp)
// ---------------------------------------------------------------------------
module apb_mtimer
    import apb_mtimer_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 12,
    parameter int          WAIT_STATES    = 0,
    parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    output logic                  pready,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic [31:0]           pwdata,
    input  logic [3:0]            pwstrb,
    output logic [31:0]           prdata,
    output logic                  pslverr,
    output logic [63:0]           mtime,
    output logic                  mtimer_int
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    // Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by
    // access cycles (psel=1, penable=1). The access completes in the cycle
    // where pready=1, which happens once wait_cnt has counted WAIT_STATES
    // access cycles. Only the completing cycle has effects: writes commit at
    // the edge ending it, and prdata/pslverr are valid only while pready=1.
    // Dropping psel before completion abandons the transfer.
    logic [3:0]  wait_cnt;
    logic        access;
    logic        complete;

    assign access   = psel & penable;
    assign complete = access & (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (!psel || complete) begin
            wait_cnt <= 4'd0;
        end else if (access && (wait_cnt < WAIT_LAST)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Address decode and write strobes
    mtimer_reg_e reg_sel;
    logic        addr_err;
    logic        wr_en;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic        wr_prescale;

    assign reg_sel     = decode_reg(32'(paddr));
    assign addr_err    = (reg_sel == REG_NONE);
    assign wr_en       = complete & pwrite & ~addr_err;
    assign wr_mtime_lo = wr_en & (reg_sel == REG_MTIME_LO);
    assign wr_mtime_hi = wr_en & (reg_sel == REG_MTIME_HI);
    assign wr_cmp_lo   = wr_en & (reg_sel == REG_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_en & (reg_sel == REG_MTIMECMP_HI);
    assign wr_ctrl     = wr_en & (reg_sel == REG_CTRL);
    assign wr_prescale = wr_en & (reg_sel == REG_PRESCALE);

    // Register file
    logic [63:0] mtime_q;
    logic [63:0] cmp_q;
    logic        en_q;
    logic [15:0] prescale_q;
    logic        int_q;

    logic        tick;
    logic        prescale_clear;

    // Only a write that actually touches PRESCALE bytes restarts the divider.
    assign prescale_clear = wr_prescale & (|pwstrb[1:0]);

    apb_mtimer_prescaler u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_q),
        .prescale (prescale_q),
        .clear    (prescale_clear),
        .tick     (tick)
    );

    logic [63:0] mtime_next;
    logic [63:0] cmp_next;
    logic        en_next;
    logic [15:0] prescale_next;

    // A bus write to either mtime half takes priority over a tick: the
    // increment for that cycle is dropped and no carry crosses halves.
    always_comb begin
        mtime_next = mtime_q;
        if (wr_mtime_lo) begin
            mtime_next = {mtime_q[63:32], merge_bytes(mtime_q[31:0], pwdata, pwstrb)};
        end else if (wr_mtime_hi) begin
            mtime_next = {merge_bytes(mtime_q[63:32], pwdata, pwstrb), mtime_q[31:0]};
        end else if (tick) begin
            mtime_next = mtime_q + 64'd1;
        end
    end

    always_comb begin
        cmp_next = cmp_q;
        if (wr_cmp_lo) begin
            cmp_next = {cmp_q[63:32], merge_bytes(cmp_q[31:0], pwdata, pwstrb)};
        end else if (wr_cmp_hi) begin
            cmp_next = {merge_bytes(cmp_q[63:32], pwdata, pwstrb), cmp_q[31:0]};
        end
    end

    always_comb begin
        en_next = en_q;
        if (wr_ctrl && pwstrb[0]) begin
            en_next = pwdata[0];
        end
    end

    always_comb begin
        prescale_next = prescale_q;
        if (wr_prescale) begin
            prescale_next[15:8] = pwstrb[1] ? pwdata[15:8] : prescale_q[15:8];
            prescale_next[7:0]  = pwstrb[0] ? pwdata[7:0]  : prescale_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= 64'd0;
            cmp_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q       <= 1'b1;
            prescale_q <= PRESCALE_RESET;
            int_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_next;
            cmp_q      <= cmp_next;
            en_q       <= en_next;
            prescale_q <= prescale_next;
            // Compare the post-update values so the interrupt tracks the
            // registers without an extra cycle of lag.
            int_q      <= (mtime_next >= cmp_next);
        end
    end

    // Read path
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel)
            REG_MTIME_LO:    rd_mux = mtime_q[31:0];
            REG_MTIME_HI:    rd_mux = mtime_q[63:32];
            REG_MTIMECMP_LO: rd_mux = cmp_q[31:0];
            REG_MTIMECMP_HI: rd_mux = cmp_q[63:32];
            REG_CTRL:        rd_mux = {31'd0, en_q};
            REG_PRESCALE:    rd_mux = {16'd0, prescale_q};
            default:         rd_mux = 32'd0;
        endcase
    end

    // Responses are gated by rst_n so the bus sees all-zero while in reset.
    assign pready     = rst_n & complete;
    assign pslverr    = rst_n & complete & addr_err;
    assign prdata     = (rst_n & complete & ~pwrite & ~addr_err) ? rd_mux : 32'd0;
    assign mtime      = mtime_q;
    assign mtimer_int = int_q;

endmodule

// File: tb/tb_apb_mtimer.sv
// ---------------------------------------------------------------------------
// tb_apb_mtimer
//   Self-checking bench for apb_mtimer built with WAIT_STATES=3. A
//   behavioural model of the timer and register map is stepped on every
//   clock; a compare process checks all outputs against it each negedge.
//   Directed sequences pin the model with literal expectations, followed by
//   randomized APB traffic, aborted transfers and a mid-transfer reset.
// ---------------------------------------------------------------------------
module tb_apb_mtimer;

    localparam int AW = 12;
    localparam int WS = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pready;
    logic [AW-1:0] paddr = '0;
    logic          pwrite = 1'b0;
    logic [31:0]   pwdata = '0;
    logic [3:0]    pwstrb = '0;
    logic [31:0]   prdata;
    logic          pslverr;
    logic [63:0]   mtime;
    logic          mtimer_int;

    int tests = 0;
    int failures = 0;

    apb_mtimer #(
        .ADDR_WIDTH     (AW),
        .WAIT_STATES    (WS),
        .PRESCALE_RESET (16'd0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .psel       (psel),
        .penable    (penable),
        .pready     (pready),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pwstrb     (pwstrb),
        .prdata     (prdata),
        .pslverr    (pslverr),
        .mtime      (mtime),
        .mtimer_int (mtimer_int)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mtime = 64'd0;
    logic [63:0] m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        m_en    = 1'b1;
    logic [15:0] m_pre   = 16'd0;
    int          m_pcnt  = 0;   // clocks elapsed in the current tick period
    int          m_acc   = 0;   // access cycles already spent in this transfer
    logic        m_int   = 1'b0;

    function automatic logic mapped(input logic [AW-1:0] a);
        return (a[1:0] == 2'b00) && (a <= 12'h014);
    endfunction

    function automatic logic [31:0] put_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        if (s[0]) r[7:0]   = new_v[7:0];
        if (s[1]) r[15:8]  = new_v[15:8];
        if (s[2]) r[23:16] = new_v[23:16];
        if (s[3]) r[31:24] = new_v[31:24];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        case (a)
            12'h000: return m_mtime[31:0];
            12'h004: return m_mtime[63:32];
            12'h008: return m_cmp[31:0];
            12'h00C: return m_cmp[63:32];
            12'h010: return {31'd0, m_en};
            12'h014: return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mtime = 64'd0;
            m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
            m_en    = 1'b1;
            m_pre   = 16'd0;
            m_pcnt  = 0;
            m_acc   = 0;
            m_int   = 1'b0;
        end else begin
            logic        done, wr, tick;
            logic [63:0] n_mtime, n_cmp;
            logic        n_en;
            logic [15:0] n_pre;
            logic [31:0] tmp;
            int          n_pcnt;

            done = psel && penable && (m_acc == WS);
            wr   = done && pwrite && mapped(paddr);
            // mtime advances once every m_pre+1 enabled clocks
            tick = m_en && (m_pcnt == int'(m_pre));
            n_pcnt  = m_en ? (tick ? 0 : m_pcnt + 1) : m_pcnt;
            n_mtime = tick ? m_mtime + 64'd1 : m_mtime;
            n_cmp   = m_cmp;
            n_en    = m_en;
            n_pre   = m_pre;
            if (wr) begin
                case (paddr)
                    12'h000: n_mtime = {m_mtime[63:32], put_bytes(m_mtime[31:0], pwdata, pwstrb)};
                    12'h004: n_mtime = {put_bytes(m_mtime[63:32], pwdata, pwstrb), m_mtime[31:0]};
                    12'h008: n_cmp   = {m_cmp[63:32], put_bytes(m_cmp[31:0], pwdata, pwstrb)};
                    12'h00C: n_cmp   = {put_bytes(m_cmp[63:32], pwdata, pwstrb), m_cmp[31:0]};
                    12'h010: if (pwstrb[0]) n_en = pwdata[0];
                    12'h014: begin
                        tmp   = put_bytes({16'd0, m_pre}, pwdata, {2'b00, pwstrb[1:0]});
                        n_pre = tmp[15:0];
                        if (pwstrb[1:0] != 2'b00) n_pcnt = 0;
                    end
                    default: ;
                endcase
            end
            if (!psel || done) m_acc = 0;
            else if (psel && penable) m_acc = m_acc + 1;
            m_mtime = n_mtime;
            m_cmp   = n_cmp;
            m_en    = n_en;
            m_pre   = n_pre;
            m_pcnt  = n_pcnt;
            m_int   = (n_mtime >= n_cmp);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic        e_rdy, e_err;
        logic [31:0] e_rd;
        e_rdy = rst_n && psel && penable && (m_acc == WS);
        e_err = e_rdy && !mapped(paddr);
        e_rd  = (e_rdy && !pwrite && mapped(paddr)) ? model_read(paddr) : 32'd0;
        check("pready",     pready,     e_rdy);
        check("pslverr",    pslverr,    e_err);
        check("prdata",     prdata,     e_rd);
        check("mtime",      mtime,      m_mtime);
        check("mtimer_int", mtimer_int, m_int);
    end

    // ---------------- driver tasks ----------------
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int ncyc);
        rdata = 32'd0;
        err   = 1'b0;
        ncyc  = 0;
        @(posedge clk); #2;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pwstrb = strb;
        @(posedge clk); #2;
        penable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (pready) begin
                rdata = prdata;
                err   = pslverr;
                ncyc  = i;
            end
            @(posedge clk); #2;
            if (ncyc != 0) break;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        if (ncyc == 0) check("xfer_timeout", 64'd1, 64'd0);
    endtask

    task automatic apb_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] rd;
        logic        e;
        int          n;
        apb_xfer(1'b1, addr, data, strb, rd, e, n);
    endtask

    task automatic apb_read(input logic [AW-1:0] addr, output logic [31:0] rdata, output logic err);
        int n;
        apb_xfer(1'b0, addr, 32'd0, 4'h0, rdata, err, n);
    endtask

    // Setup plus a few access cycles, then psel drops before completion.
    task automatic apb_abort(input logic [AW-1:0] addr, input logic [31:0] data, input int acc_cycles);
        @(posedge clk); #2;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data; pwstrb = 4'hF;
        @(posedge clk); #2;
        penable = 1'b1;
        repeat (acc_cycles) begin
            @(posedge clk); #2;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #2;
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (cycles) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic        err;
        int          n, changes;
        logic [63:0] prev;
        logic [AW-1:0] addr_tab[10];

        addr_tab = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                     12'h018, 12'h002, 12'h1F0, 12'h007};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset values and wait-state timing
        apb_xfer(1'b0, 12'h008, 32'd0, 4'h0, rd, err, n);
        check("rst_cmp_lo", rd, 32'hFFFF_FFFF);
        check("rst_cmp_lo_err", err, 1'b0);
        check("wait_cycles", n, 4);
        apb_read(12'h00C, rd, err);
        check("rst_cmp_hi", rd, 32'hFFFF_FFFF);
        check("rst_int", mtimer_int, 1'b0);
        apb_read(12'h014, rd, err);
        check("rst_prescale", rd, 32'd0);
        apb_read(12'h010, rd, err);
        check("rst_ctrl", rd, 32'd1);

        // Carry from LO into HI with PRESCALE=0 (tick every clock)
        apb_write(12'h000, 32'hFFFF_FFFE, 4'hF);
        check("carry_t0", mtime, 64'h0000_0000_FFFF_FFFE);
        @(posedge clk); #2;
        check("carry_t1", mtime, 64'h0000_0000_FFFF_FFFF);
        @(posedge clk); #2;
        check("carry_t2", mtime, 64'h0000_0001_0000_0000);
        apb_read(12'h004, rd, err);
        check("carry_hi", rd, 32'd1);

        // Interrupt on compare
        apb_write(12'h00C, 32'd0, 4'hF);
        apb_write(12'h008, 32'd10, 4'hF);
        apb_write(12'h004, 32'd0, 4'hF);
        apb_write(12'h000, 32'd0, 4'hF);
        check("int_after_clear", mtimer_int, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mtime == 64'd9)  check("int_at_9", mtimer_int, 1'b0);
            if (mtime == 64'd10) begin
                check("int_at_10", mtimer_int, 1'b1);
                n = 1;
                break;
            end
        end
        check("int_seen_10", n, 1);
        apb_write(12'h008, 32'd100, 4'hF);
        check("int_dropped", mtimer_int, 1'b0);

        // Error responses
        apb_read(12'h018, rd, err);
        check("err_rd_flag", err, 1'b1);
        check("err_rd_data", rd, 32'd0);
        apb_xfer(1'b1, 12'h002, 32'hDEAD_BEEF, 4'hF, rd, err, n);
        check("err_wr_flag", err, 1'b1);
        apb_read(12'h008, rd, err);
        check("err_no_change", rd, 32'd100);

        // Prescaler: 5 increments in any 25 consecutive clocks
        apb_write(12'h014, 32'd4, 4'hF);
        apb_write(12'h010, 32'd1, 4'hF);
        @(negedge clk);
        prev = mtime;
        changes = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (mtime != prev) changes++;
            prev = mtime;
        end
        check("prescale4_ticks", changes, 5);

        // Disabled timer holds and byte-strobe merge
        apb_write(12'h010, 32'd0, 4'hF);
        apb_write(12'h000, 32'h1234_5678, 4'hF);
        apb_write(12'h004, 32'hCAFE_0001, 4'hF);
        repeat (20) @(posedge clk);
        #2;
        check("frozen", mtime, 64'hCAFE_0001_1234_5678);
        apb_write(12'h000, 32'h0000_AB00, 4'b0010);
        apb_read(12'h000, rd, err);
        check("strobe_merge", rd, 32'h1234_AB78);
        apb_write(12'h004, 32'hFFFF_FFFF, 4'h0);
        apb_read(12'h004, rd, err);
        check("strobe_none", rd, 32'hCAFE_0001);

        // Tick-cycle writes: tick every clock, strobed write to MTIME_LO
        apb_write(12'h014, 32'd0, 4'hF);
        apb_write(12'h010, 32'd1, 4'hF);
        apb_write(12'h000, 32'h0000_CD00, 4'b0010);
        apb_write(12'h004, 32'h0000_00FF, 4'b0001);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic [AW-1:0] a;
            logic [31:0]   d;
            logic [3:0]    s;
            a = addr_tab[$urandom_range(0, 9)];
            d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            s = 4'($urandom_range(0, 15));
            if (a == 12'h014) d = 32'($urandom_range(0, 3));
            if (a == 12'h010) d = {31'd0, ($urandom_range(0, 3) != 0)};
            if ($urandom_range(0, 9) == 0) begin
                apb_abort(a, d, $urandom_range(0, WS));
            end else if ($urandom_range(0, 1) == 0) begin
                apb_write(a, d, s);
            end else begin
                apb_read(a, rd, err);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Reset in the middle of an access phase
        @(posedge clk); #2;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'd5; pwstrb = 4'hF;
        @(posedge clk); #2;
        penable = 1'b1;
        @(posedge clk); #2;
        do_reset(3);
        apb_read(12'h008, rd, err);
        check("midrst_cmp_lo", rd, 32'hFFFF_FFFF);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
